// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
// The master issues operands and the start strobe, the slave returns the product.
interface shift_add_multiplier_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]   multiplicand_i;
    logic [DATA_WIDTH-1:0]   multiplier_i;
    logic                    data_valid_i;
    logic [2*DATA_WIDTH-1:0] product_o;
    logic                    data_valid_o;
    logic                    idle_o;

    modport master (
        output multiplicand_i,
        output multiplier_i,
        output data_valid_i,
        input  product_o,
        input  data_valid_o,
        input  idle_o
    );

    modport slave (
        input  multiplicand_i,
        input  multiplier_i,
        input  data_valid_i,
        output product_o,
        output data_valid_o,
        output idle_o
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier, one multiplier bit per enabled cycle.
// Shares the start/valid/idle handshake of the iterative divider.
module shift_add_multiplier #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clk_en_i,
    shift_add_multiplier_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MULTIPLY,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [2*W:0]    acc_q, acc_d;
    logic [2*W-1:0]  product_q, product_d;
    logic            valid_q, valid_d;
    logic [W:0]      sum;
    logic [2*W:0]    shifted;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        valid_d   = valid_q;
        // carry is always zero entering an iteration; it is the sum's top bit
        sum       = acc_q[2*W:W] + (acc_q[0] ? {1'b0, mcand_q} : '0);
        shifted   = {sum, acc_q[W-1:0]};
        if (clk_en_i) begin
            valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    mcand_d = bus.multiplicand_i;
                    acc_d   = {1'b0, {W{1'b0}}, bus.multiplier_i};
                    cnt_d   = '0;
                    if (bus.data_valid_i) begin
                        state_d = MULTIPLY;
                    end
                end
                MULTIPLY: begin
                    acc_d = {1'b0, shifted[2*W:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = FINISH;
                    end
                end
                FINISH: begin
                    product_d = acc_q[2*W-1:0];
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mcand_q <= mcand_d;
        acc_q   <= acc_d;
    end

    assign bus.product_o    = product_q;
    assign bus.data_valid_o = valid_q;
    assign bus.idle_o       = (state_d == IDLE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: plain a*b products with a
// busy-interval latency model, checked by a negedge monitor.
module tb_shift_add_multiplier;
    localparam int W  = 16;
    localparam int W2 = 2 * W;

    logic clk_i    = 1'b0;
    logic rst_i    = 1'b1;
    logic clk_en_i = 1'b1;

    shift_add_multiplier_if #(.DATA_WIDTH(W)) bus ();

    shift_add_multiplier #(.DATA_WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clk_en_i (clk_en_i),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W2-1:0] prod;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            en_cyc = 0;
    int            busy = 0;
    bit            model_valid = 0;
    bit            last_en = 0;
    bit            accepted = 0;
    bit            armed = 0;
    logic [W2-1:0] last_prod = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an op occupies W+1 enabled edges after its start edge
    // and completes on the last of them; starts are taken only when free.
    initial forever begin
        @(posedge clk_i);
        accepted = 0;
        if (rst_i) begin
            busy = 0;
            sb.delete();
            last_prod = '0;
            model_valid = 0;
            last_en = 0;
            armed = 1;
        end else if (clk_en_i) begin
            last_en = 1;
            en_cyc++;
            if (busy == 0) begin
                model_valid = 0;
                if (bus.data_valid_i) begin
                    sb.push_back('{prod: W2'(bus.multiplicand_i) *
                                         W2'(bus.multiplier_i),
                                   due: en_cyc + W + 1});
                    busy = W + 1;
                    accepted = 1;
                end
            end else begin
                model_valid = (busy == 1);
                busy--;
            end
        end else begin
            last_en = 0;
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (armed) begin
            exp_t e;
            check("valid", bus.data_valid_o, model_valid);
            if (bus.data_valid_o === 1'b1 && last_en) begin
                if (sb.size() == 0) begin
                    check("spurious_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("product", bus.product_o, e.prod);
                    check("latency", en_cyc, e.due);
                    last_prod = e.prod;
                end
            end else begin
                check("held_product", bus.product_o, last_prod);
            end
            if (clk_en_i && !rst_i) begin
                check("idle", bus.idle_o,
                      (busy == 1) || (busy == 0 && !bus.data_valid_i));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_en(input bit r);
        clk_en_i = r ? ($urandom_range(3) != 0) : 1'b1;
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit r);
        int n = 0;
        bus.multiplicand_i = a;
        bus.multiplier_i   = b;
        bus.data_valid_i   = 1'b1;
        do begin
            set_en(r);
            step();
            n++;
        end while (!accepted && n < 100);
        bus.data_valid_i   = 1'b0;
        bus.multiplicand_i = W'($urandom);
        bus.multiplier_i   = W'($urandom);
        clk_en_i = 1'b1;
    endtask

    task automatic wait_idle(input bit r);
        int n = 0;
        while (busy != 0 && n < 500) begin
            set_en(r);
            step();
            n++;
        end
        clk_en_i = 1'b1;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit r);
        start(a, b, r);
        wait_idle(r);
        step();
    endtask

    initial begin
        int n;
        bus.multiplicand_i = '0;
        bus.multiplier_i   = '0;
        bus.data_valid_i   = 1'b0;
        repeat (3) step();
        rst_i = 1'b0;
        step();
        check("rst_product", bus.product_o, 0);
        check("rst_valid", bus.data_valid_o, 0);
        check("rst_idle", bus.idle_o, 1);

        op(16'd3, 16'd5, 0);
        op(16'hFFFF, 16'hFFFF, 0);
        op(16'h8000, 16'h0002, 0);
        op(16'h0000, 16'h1234, 0);
        op(16'h1234, 16'h0000, 0);

        // start held high; operand change mid-op only affects the second op
        bus.multiplicand_i = 16'd7;
        bus.multiplier_i   = 16'd9;
        bus.data_valid_i   = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 10);
        repeat (5) step();
        bus.multiplier_i = 16'hAAAA;
        repeat (13) step();
        bus.data_valid_i = 1'b0;
        wait_idle(0);
        step();

        start(16'h1234, 16'h0100, 0);
        repeat (6) step();
        clk_en_i = 1'b0;
        repeat (5) step();
        clk_en_i = 1'b1;
        n = 0;
        while (bus.data_valid_o !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check("pulse_seen", bus.data_valid_o, 1);
        clk_en_i = 1'b0;
        repeat (3) step();
        clk_en_i = 1'b1;
        wait_idle(0);
        step();

        start(16'hBEEF, 16'h1234, 0);
        repeat (7) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_product", bus.product_o, 0);
        check("midrst_valid", bus.data_valid_o, 0);
        check("midrst_idle", bus.idle_o, 1);
        op(16'd2, 16'd3, 0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if (i % 7 == 0) a = 16'hFFFF;
            if (i % 5 == 0) b = 16'hFFFF;
            op(a, b, 1);
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (4) step();
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
